// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath control blocks: state encoding,
// default transform size and a constant clog2 helper.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PREP  = 2'b01,
    COUNT = 2'b11
  } state_e;

  localparam int N_POINTS_DEF = 64;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/bit_reverse.sv
// Combinational bit reversal across W bits; shared by the FFT address
// generators to map between natural and bit-reversed order.
module bit_reverse #(
  parameter int W = 6
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  for (genvar i = 0; i < W; i++) begin : g_rev
    assign dout[i] = din[W-1-i];
  end

endmodule

// File: rtl/fft_output_sequencer.sv
// FFT output-phase sequencer: read index, valid strobe, in_ctrl/hold and frame
// markers. FFT_OUTPUT_SEQUENCER_BITREV_EN presents counter_o bit-reversed.
module fft_output_sequencer
  import fft_pkg::*;
#(
  parameter  int N_POINTS    = N_POINTS_DEF,
  parameter  int CTRL_WIN    = 8,
  parameter  int PREP_CYCLES = 1,
  localparam int CW          = clog2(N_POINTS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dataind,
  output logic [CW-1:0] counter_o,
  output logic          datavalid,
  output logic          in_ctrl_all_out,
  output logic          hold_all_out,
  output logic          frame_done,
  output logic          start_lost
);

  localparam logic [CW-1:0] CNT_PARK  = '1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(N_POINTS - 2);
  localparam logic [CW-1:0] CNT_WIN   = CW'(CTRL_WIN);
  localparam logic [3:0]    PREP_LAST = 4'(PREP_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    prep_q, prep_d;
  logic          dv_q, dv_d;
  logic          ic_q, ic_d;
  logic          hold_q, hold_d;
  logic          fd_q, fd_d;
  logic          lost_q, lost_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prep_d  = prep_q;
    dv_d    = 1'b0;
    ic_d    = 1'b0;
    hold_d  = 1'b1;
    fd_d    = 1'b0;
    lost_d  = lost_q;
    case (state_q)
      IDLE: begin
        // The last beat is shown from IDLE, so a start here is back-to-back.
        if (dataind) begin
          state_d = PREP;
          cnt_d   = '0;
          prep_d  = '0;
          ic_d    = 1'b1;
          hold_d  = 1'b0;
        end
      end
      PREP: begin
        lost_d = lost_q | dataind;
        cnt_d  = '0;
        ic_d   = 1'b1;
        hold_d = 1'b0;
        if (prep_q == PREP_LAST) begin
          state_d = COUNT;
          dv_d    = 1'b1;
        end else begin
          prep_d = prep_q + 4'd1;
        end
      end
      COUNT: begin
        lost_d = lost_q | dataind;
        dv_d   = 1'b1;
        hold_d = 1'b0;
        ic_d   = (cnt_q < CNT_WIN);
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = CNT_PARK;
          fd_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= CNT_PARK;
      prep_q  <= '0;
      dv_q    <= 1'b0;
      ic_q    <= 1'b0;
      hold_q  <= 1'b1;
      fd_q    <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prep_q  <= prep_d;
      dv_q    <= dv_d;
      ic_q    <= ic_d;
      hold_q  <= hold_d;
      fd_q    <= fd_d;
      lost_q  <= lost_d;
    end
  end

`ifdef FFT_OUTPUT_SEQUENCER_BITREV_EN
  bit_reverse #(.W(CW)) u_bit_reverse (
    .din  (cnt_q),
    .dout (counter_o)
  );
`else
  assign counter_o = cnt_q;
`endif

  assign datavalid       = dv_q;
  assign in_ctrl_all_out = ic_q;
  assign hold_all_out    = hold_q;
  assign frame_done      = fd_q;
  assign start_lost      = lost_q;

endmodule

// File: tb/tb_fft_output_sequencer.sv
// Bench for fft_output_sequencer: three configurations checked every cycle
// against a frame-phase model, plus literal expectations for key beats.
module tb_fft_output_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v;
  logic [2:0] din;
  logic [9:0] cnt_w [3];
  logic [2:0] dv_w, ic_w, hd_w, fd_w, sl_w;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  function automatic logic [9:0] disp(input logic [9:0] v, input int w);
    logic [9:0] r;
    r = v;
`ifdef FFT_OUTPUT_SEQUENCER_BITREV_EN
    r = '0;
    for (int i = 0; i < w; i++) r[i] = v[w-1-i];
`else
    if (w < 0) r = '0;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_beat(input int g, input logic [9:0] v);
    int t;
    t = 0;
    while (!(dv_w[g] && cnt_w[g] == v) && t < 3000) begin
      tick(1);
      t++;
    end
    if (t >= 3000) begin
      vectors++;
      miscompares++;
      $display("FAIL wait cfg%0d beat %0d: timed out", g, v);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int N    = (g == 0) ? 64 : (g == 1) ? 16 : 8;
    localparam int CWIN = (g == 0) ? 8 : (g == 1) ? 3 : 2;
    localparam int P    = (g == 1) ? 4 : 1;
    localparam int CWB  = $clog2(N);

    logic [CWB-1:0] cnt;
    logic dv, ic, hd, fd, sl;

    fft_output_sequencer #(.N_POINTS(N), .CTRL_WIN(CWIN), .PREP_CYCLES(P)) dut (
      .clk             (clk),
      .rst             (rst_v[g]),
      .dataind         (din[g]),
      .counter_o       (cnt),
      .datavalid       (dv),
      .in_ctrl_all_out (ic),
      .hold_all_out    (hd),
      .frame_done      (fd),
      .start_lost      (sl)
    );

    assign cnt_w[g] = 10'(cnt);
    assign dv_w[g]  = dv;
    assign ic_w[g]  = ic;
    assign hd_w[g]  = hd;
    assign fd_w[g]  = fd;
    assign sl_w[g]  = sl;

    // ph: 0 idle, 1..P prep, P+1..P+N beats k=0..N-1 of the displayed cycle.
    int ph   = 0;
    bit lost = 1'b0;

    always @(posedge clk) begin
      if (rst_v[g]) begin
        ph   = 0;
        lost = 1'b0;
      end else if ((ph == 0 || ph == P + N) && din[g]) begin
        ph = 1;
      end else if (ph != 0 && ph < P + N) begin
        if (din[g]) lost = 1'b1;
        ph++;
      end else begin
        ph = 0;
      end
    end

    always @(negedge clk) begin
      int k;
      logic [9:0] ec;
      logic edv, eic, ehd, efd;
      if (chk_en) begin
        k = ph - P - 1;
        if (ph == 0) begin
          ec = 10'(N - 1); edv = 0; eic = 0; ehd = 1; efd = 0;
        end else if (ph <= P) begin
          ec = '0; edv = 0; eic = 1; ehd = 0; efd = 0;
        end else begin
          ec = disp(10'(k), CWB); edv = 1; eic = (k <= CWIN); ehd = 0; efd = (k == N - 1);
        end
        chk($sformatf("cfg%0d counter_o", g), 32'(cnt_w[g]), 32'(ec));
        chk($sformatf("cfg%0d datavalid", g), 32'(dv), 32'(edv));
        chk($sformatf("cfg%0d in_ctrl", g), 32'(ic), 32'(eic));
        chk($sformatf("cfg%0d hold", g), 32'(hd), 32'(ehd));
        chk($sformatf("cfg%0d frame_done", g), 32'(fd), 32'(efd));
        chk($sformatf("cfg%0d start_lost", g), 32'(sl), 32'(lost));
      end
    end
  end

  initial begin
    int beats;
    bit seen;
    logic [9:0] br [8];
`ifdef FFT_OUTPUT_SEQUENCER_BITREV_EN
    br = '{10'd0, 10'd4, 10'd2, 10'd6, 10'd1, 10'd5, 10'd3, 10'd7};
`else
    br = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7};
`endif
    rst_v = 3'b111;
    din   = 3'b000;
    tick(3);
    rst_v  = 3'b000;
    chk_en = 1'b1;
    tick(2);

    // reset state
    chk("rst counter", 32'(cnt_w[0]), 63);
    chk("rst datavalid", 32'(dv_w[0]), 0);
    chk("rst hold", 32'(hd_w[0]), 1);
    chk("rst in_ctrl", 32'(ic_w[0]), 0);
    chk("rst frame_done", 32'(fd_w[0]), 0);
    chk("rst start_lost", 32'(sl_w[0]), 0);

    // single frame, 64 points, PREP 1
    din[0] = 1'b1; tick(1); din[0] = 1'b0;
    chk("prep datavalid", 32'(dv_w[0]), 0);
    chk("prep in_ctrl", 32'(ic_w[0]), 1);
    chk("prep hold", 32'(hd_w[0]), 0);
    tick(1);
    for (int i = 0; i < 64; i++) begin
      chk("f64 datavalid", 32'(dv_w[0]), 1);
      chk("f64 counter", 32'(cnt_w[0]), 32'(disp(10'(i), 6)));
      chk("f64 in_ctrl", 32'(ic_w[0]), 32'(i <= 8));
      chk("f64 frame_done", 32'(fd_w[0]), 32'(i == 63));
      tick(1);
    end
    chk("f64 end datavalid", 32'(dv_w[0]), 0);
    chk("f64 end hold", 32'(hd_w[0]), 1);
    chk("f64 end counter", 32'(cnt_w[0]), 63);
    tick(3);

    // back-to-back frames
    beats = 0; seen = 1'b0;
    din[0] = 1'b1; tick(1); din[0] = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (dv_w[0]) beats++;
      din[0] = dv_w[0] && cnt_w[0] == 10'd63 && !seen;
      if (din[0]) seen = 1'b1;
      tick(1);
    end
    din[0] = 1'b0;
    chk("b2b beats", 32'(beats), 128);
    chk("b2b start_lost", 32'(sl_w[0]), 0);

    // busy request at counter 20
    din[0] = 1'b1; tick(1); din[0] = 1'b0;
    wait_beat(0, 10'd20);
    din[0] = 1'b1; tick(1); din[0] = 1'b0;
    chk("busy start_lost", 32'(sl_w[0]), 1);
    wait_beat(0, 10'd63);
    chk("busy frame_done", 32'(fd_w[0]), 1);
    tick(2);
    chk("busy sticky", 32'(sl_w[0]), 1);
    rst_v[0] = 1'b1; tick(1); rst_v[0] = 1'b0;
    chk("busy rst clears", 32'(sl_w[0]), 0);

    // reset mid-frame at counter 30
    din[0] = 1'b1; tick(1); din[0] = 1'b0;
    wait_beat(0, 10'd30);
    rst_v[0] = 1'b1; tick(1); rst_v[0] = 1'b0;
    chk("midrst counter", 32'(cnt_w[0]), 63);
    chk("midrst datavalid", 32'(dv_w[0]), 0);
    chk("midrst hold", 32'(hd_w[0]), 1);
    chk("midrst in_ctrl", 32'(ic_w[0]), 0);
    chk("midrst frame_done", 32'(fd_w[0]), 0);
    tick(2);

    // 16 points, CTRL_WIN 3, PREP 4
    din[1] = 1'b1; tick(1); din[1] = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      chk("n16 prep datavalid", 32'(dv_w[1]), 0);
      tick(1);
    end
    for (int i = 0; i < 16; i++) begin
      chk("n16 datavalid", 32'(dv_w[1]), 1);
      chk("n16 counter", 32'(cnt_w[1]), 32'(disp(10'(i), 4)));
      chk("n16 in_ctrl", 32'(ic_w[1]), 32'(i <= 3));
      tick(1);
    end
    chk("n16 end hold", 32'(hd_w[1]), 1);

    // 8 points: output order and parked value
    chk("n8 parked", 32'(cnt_w[2]), 7);
    din[2] = 1'b1; tick(1); din[2] = 1'b0; tick(1);
    for (int i = 0; i < 8; i++) begin
      chk("n8 datavalid", 32'(dv_w[2]), 1);
      chk("n8 counter", 32'(cnt_w[2]), 32'(br[i]));
      tick(1);
    end
    chk("n8 end datavalid", 32'(dv_w[2]), 0);
    chk("n8 end parked", 32'(cnt_w[2]), 7);

    // random starts and resets on all configurations
    for (int t = 0; t < 4000; t++) begin
      for (int g = 0; g < 3; g++) begin
        din[g]   = ($urandom_range(15) == 0);
        rst_v[g] = ($urandom_range(599) == 0);
      end
      tick(1);
    end
    din = '0; rst_v = '0;
    tick(100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
